// File: rtl/quad_count_pkg.sv
// rtl/quad_count_pkg.sv - shared types and helpers for the quad BCD counter sequencer
package quad_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // Non-decimal nibbles (A..F) saturate to 9 so the counter never holds an illegal digit.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/quad_count_ctrl_bcd_digit.sv
// rtl/quad_count_ctrl_bcd_digit.sv - one BCD decade with load, clear and up/down step
module bcd_digit
  import quad_count_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       up_dn,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       borrow_out
);

  // carry/borrow only flag the rollover condition; the parent gates them with the tick.
  assign carry_out  = (q == BCD_MAX);
  assign borrow_out = (q == BCD_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= BCD_MIN;
    end else if (clr) begin
      q <= BCD_MIN;
    end else if (ld) begin
      q <= bcd_clamp(ld_val);
    end else if (en) begin
      if (up_dn) q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      else       q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/quad_count_ctrl.sv
// rtl/quad_count_ctrl.sv - run-control sequencer gating the 1 Hz tick into a BCD up/down counter
module quad_count_ctrl
  import quad_count_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  up_dn,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [1:0]            state,
  output logic                  running,
  output logic                  tc
);

  state_t              state_q;
  state_t              state_d;
  logic                tc_d;
  logic                cnt_tick;
  logic                ld_en;
  logic                hi_max;
  logic                hi_min;
  logic                hit_term;
  logic [DIGITS-1:0]   carry;
  logic [DIGITS-1:0]   borrow;
  logic [DIGITS:0]     up_chain;
  logic [DIGITS:0]     dn_chain;

  // Any command in the same cycle outranks the tick, even one that ends up ignored.
  assign cnt_tick = (state_q == RUN) & tick & ~clear & ~load & ~stop & ~start;
  assign ld_en    = load & ~clear & (state_q != RUN);

  assign up_chain[0] = 1'b1;
  assign dn_chain[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic en_i;
    assign en_i          = cnt_tick & (up_dn ? up_chain[i] : dn_chain[i]);
    assign up_chain[i+1] = up_chain[i] & carry[i];
    assign dn_chain[i+1] = dn_chain[i] & borrow[i];

    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clear),
      .en         (en_i),
      .up_dn      (up_dn),
      .ld         (ld_en),
      .ld_val     (load_val[4*i +: 4]),
      .q          (bcd[4*i +: 4]),
      .carry_out  (carry[i]),
      .borrow_out (borrow[i])
    );
  end

  // The next counted tick lands on the terminal value when only the lowest digit is one step away.
  always_comb begin
    hi_max = 1'b1;
    hi_min = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      hi_max = hi_max & carry[i];
      hi_min = hi_min & borrow[i];
    end
  end

  assign hit_term = up_dn ? (hi_max && (bcd[3:0] == BCD_MAX - 4'd1))
                          : (hi_min && (bcd[3:0] == BCD_MIN + 4'd1));

  always_comb begin
    state_d = state_q;
    tc_d    = cnt_tick & hit_term;
    if (clear) begin
      state_d = IDLE;
    end else if (load) begin
      if (state_q == DONE) state_d = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (start) begin
      if (state_q == IDLE || state_q == PAUSE) state_d = RUN;
    end else if (cnt_tick && hit_term && !WRAP) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      running <= 1'b0;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == RUN);
      tc      <= tc_d;
    end
  end

  assign state = state_q;

endmodule
